// File: rtl/bus_capture_fifo.sv
// Capture FIFO for the three-register bus: samples {bus_state, bus_data} from
// enabled states and presents them first-word-fall-through on a valid/ready port.
module bus_capture_fifo #(
    parameter int                   DATA_W       = 4,
    parameter int                   ST_W         = 2,
    parameter int                   ADDR_W       = 3,
    parameter logic [(1<<ST_W)-1:0] CAPTURE_MASK = 4'b1110
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] bus_data,
    input  logic [ST_W-1:0]   bus_state,
    input  logic              capture_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ST_W-1:0]   out_src,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic [7:0]        drop_cnt,
    input  logic              clear_ovf
);

    localparam int                ENTRY_W = ST_W + DATA_W;
    localparam int                DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   CNT_MAX = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [ENTRY_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [ADDR_W:0]   count_q,    count_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;

    logic               push_req;
    logic               push;
    logic               pop;
    logic               drop;
    logic [ENTRY_W-1:0] head_entry;

    assign full      = (count_q == CNT_MAX);
    assign empty     = (count_q == '0);
    assign out_valid = !empty;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

    assign push_req = capture_en & CAPTURE_MASK[bus_state];
    assign pop      = out_valid & out_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push     = push_req & (!full | pop);
    assign drop     = push_req & full & !pop;

    assign head_entry = mem[rd_ptr_q];
    assign out_data   = empty ? '0 : head_entry[DATA_W-1:0];
    assign out_src    = empty ? '0 : head_entry[ENTRY_W-1:DATA_W];

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end

        if (clear_ovf) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // NOTE: storage has no reset; stale entries are unreachable because empty masks the head.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {bus_state, bus_data};
        end
    end

endmodule

// File: tb/tb_bus_capture_fifo.sv
// Directed self-checking bench for bus_capture_fifo: reset, mask filter,
// overflow/drop accounting, full push+pop, pointer wrap and mid-run reset.
module tb_bus_capture_fifo;

    logic       clk;
    logic       rst;
    logic [3:0] bus_data;
    logic [1:0] bus_state;
    logic       capture_en;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [1:0] out_src;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic [7:0] drop_cnt;
    logic       clear_ovf;

    int checks = 0;
    int errors = 0;

    bus_capture_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .bus_data   (bus_data),
        .bus_state  (bus_state),
        .capture_en (capture_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_src    (out_src),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .clear_ovf  (clear_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        bus_data   = '0;
        bus_state  = '0;
        capture_en = 1'b0;
        out_ready  = 1'b0;
        clear_ovf  = 1'b0;
        #30;
        rst = 1'b0;
        step();

        check("rst_count",     count,     0);
        check("rst_empty",     empty,     1);
        check("rst_full",      full,      0);
        check("rst_valid",     out_valid, 0);
        check("rst_overflow",  overflow,  0);
        check("rst_drop_cnt",  drop_cnt,  0);
        check("rst_out_data",  out_data,  0);

        // Basic capture
        capture_en = 1'b1;
        bus_state  = 2'd1;
        bus_data   = 4'd9;
        check("no_bypass_valid", out_valid, 0);
        step();
        bus_state = 2'd0;
        check("basic_valid", out_valid, 1);
        check("basic_data",  out_data,  9);
        check("basic_src",   out_src,   1);
        check("basic_count", count,     1);

        // Mask filter: state 0 ignored, state 2 captured
        bus_data = 4'd7;
        repeat (5) step();
        check("mask_count", count,    1);
        check("mask_drop",  drop_cnt, 0);
        bus_state = 2'd2;
        step();
        bus_state = 2'd0;
        check("mask2_count", count, 2);
        out_ready = 1'b1;
        check("mask_head0_data", out_data, 9);
        step();
        check("mask_head1_data", out_data, 7);
        check("mask_head1_src",  out_src,  2);
        step();
        out_ready = 1'b0;
        check("mask_drained", empty,    1);
        check("mask_zero_out", out_data, 0);

        // Fill and overflow: data 0..9 from state 3, two words dropped
        bus_state = 2'd3;
        for (int i = 0; i < 10; i++) begin
            bus_data = 4'(i);
            step();
            if (i == 7) begin
                check("fill_full_at8", full,  1);
                check("fill_count8",   count, 8);
                check("fill_no_drop",  drop_cnt, 0);
            end
        end
        bus_state = 2'd0;
        check("ovf_full",     full,     1);
        check("ovf_count",    count,    8);
        check("ovf_flag",     overflow, 1);
        check("ovf_drop_cnt", drop_cnt, 2);

        // Full with simultaneous push+pop: 0 leaves, 8 joins, no drop
        check("pp_head_before", out_data, 0);
        out_ready = 1'b1;
        bus_state = 2'd3;
        bus_data  = 4'd8;
        step();
        out_ready = 1'b0;
        bus_state = 2'd0;
        check("pp_count",    count,    8);
        check("pp_drop_cnt", drop_cnt, 2);
        check("pp_head",     out_data, 1);

        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        check("clr_overflow", overflow, 0);
        check("clr_drop_cnt", drop_cnt, 0);

        // Drop and clear in the same cycle: clear wins
        bus_state = 2'd3;
        bus_data  = 4'd15;
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        check("clrwin_overflow", overflow, 0);
        check("clrwin_drop_cnt", drop_cnt, 0);
        step();
        bus_state = 2'd0;
        check("drop1_overflow", overflow, 1);
        check("drop1_drop_cnt", drop_cnt, 1);

        // Drain: expect 1..8 in order, all from state 3
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            check("drain_data", out_data, k);
            check("drain_src",  out_src,  3);
            step();
        end
        out_ready = 1'b0;
        check("drain_empty", empty, 1);
        check("drain_count", count, 0);

        // Drop counter saturation: 8 stored + 258 dropped
        bus_state = 2'd1;
        for (int i = 0; i < 266; i++) begin
            bus_data = 4'(i);
            step();
        end
        bus_state = 2'd0;
        check("sat_drop_cnt", drop_cnt, 255);
        check("sat_overflow", overflow, 1);
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        check("sat_clr", drop_cnt, 0);
        out_ready = 1'b1;
        repeat (8) step();
        out_ready = 1'b0;
        check("sat_drained", empty, 1);

        // Wrap: preload 10, then 12 push/pop pairs, head lags push by one entry
        bus_state = 2'd2;
        bus_data  = 4'd10;
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus_data = 4'(i);
            check("wrap_head", out_data, (i == 0) ? 10 : i - 1);
            step();
        end
        out_ready = 1'b0;
        bus_state = 2'd0;
        check("wrap_count", count,    1);
        check("wrap_last",  out_data, 11);

        // Mid-run reset with count = 3
        bus_state = 2'd2;
        bus_data  = 4'd12;
        step();
        bus_data = 4'd13;
        step();
        bus_state = 2'd0;
        check("pre_rst_count", count, 3);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_count", count,     0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_empty", empty,     1);
        check("mid_rst_data",  out_data,  0);
        #2;
        rst = 1'b0;
        bus_state = 2'd1;
        bus_data  = 4'd5;
        step();
        bus_state = 2'd0;
        check("post_rst_count", count,    1);
        check("post_rst_data",  out_data, 5);
        check("post_rst_src",   out_src,  1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
